router_register: RTL and testbench
==================================

ROUTER_REGISTER -- requirements
Module: router_register

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rstn  input  1  reset, asynchronous, active-low.
REQ-003 pkt_vld  input  1  source asserts while header/payload bytes are on din; deasserted for the parity byte.
REQ-004 din  input  8  packet byte stream: header {len[5:0], addr[1:0]}, payload, parity.
REQ-005 fifo_full  input  1  destination FIFO full.
REQ-006 rst_int_reg  input  1  FSM request to clear low_pkt_valid.
REQ-007 detect_addr  input  1  FSM DECODE_ADDRESS state.
REQ-008 ld_state  input  1  FSM LOAD_DATA state.
REQ-009 laf_state  input  1  FSM LOAD_AFTER_FULL state.
REQ-010 lfd_state  input  1  FSM LOAD_FIRST_DATA state.
REQ-011 full_state  input  1  FSM FIFO_FULL_STATE.
REQ-012 parity_done  output  1  packet parity byte captured.
REQ-013 low_pkt_valid  output  1  pkt_vld fell while loading.
REQ-014 err  output  1  parity mismatch flag.
REQ-015 d_out  output  8  byte to FIFO.

Function
REQ-016 Header reg SHALL load din when detect_addr=1, pkt_vld=1, din[1:0]!=2'b11; else hold.
REQ-017 d_out SHALL take, by priority: lfd_state -> header reg; ld_state && !fifo_full -> din; laf_state -> full-byte reg; otherwise hold.
REQ-018 Full-byte reg SHALL load din when ld_state=1 and fifo_full=1; else hold.
REQ-019 low_pkt_valid SHALL clear when rst_int_reg=1, else set when ld_state=1 and pkt_vld=0, else hold.
REQ-020 parity_done SHALL clear when detect_addr=1, else set when (ld_state && !fifo_full && !pkt_vld) or (laf_state && low_pkt_valid && !parity_done), else hold.
REQ-021 Internal parity (8-bit XOR accumulator) SHALL clear on detect_addr, XOR header reg on lfd_state && pkt_vld, XOR din on ld_state && pkt_vld && !full_state, else hold.
REQ-022 Packet-parity reg SHALL load din when ld_state=1, pkt_vld=0, fifo_full=0; and load full-byte reg when laf_state=1 and low_pkt_valid=1 and parity_done=0; else hold.
REQ-023 err SHALL clear on detect_addr, else while parity_done=1 be registered as (internal parity != packet parity), else hold; err valid one cycle after parity_done rises.
REQ-024 All outputs registered; no combinational input-to-output path.
REQ-025 Simultaneous state inputs are illegal from the FSM; priority of REQ-017 SHALL nonetheless be honoured.

Reset
REQ-026 rstn=0 SHALL immediately force d_out=0, parity_done=0, low_pkt_valid=0, err=0, header/full-byte/internal/packet-parity regs=0.
REQ-027 Reset mid-packet SHALL discard all accumulated parity; next packet starts clean after rstn=1.

Structure
REQ-028 Shared package SHALL hold BYTE_W=8 and ADDR_INVALID=2'b11; no typedefs needed.
REQ-029 Single flat module; no sub-module.

Verification
REQ-030 Good packet: header 0x3A (len 14, addr 2), 14 random payload bytes, correct XOR parity, fifo_full=0 -> d_out replays 0x3A then each byte one cycle later, parity_done=1 cycle after parity byte, low_pkt_valid=1, err=0.
REQ-031 Same packet with parity byte inverted -> err=1 one cycle after parity_done, held until next detect_addr.
REQ-032 fifo_full=1 during ld_state with din=0x55 -> d_out holds; then laf_state -> d_out=0x55.
REQ-033 detect_addr with din=0x3B (addr 3) -> header reg unchanged, subsequent lfd_state outputs previous header.
REQ-034 low_pkt_valid=1 then rst_int_reg=1 -> low_pkt_valid=0 next edge; detect_addr -> parity_done=0, err=0.
REQ-035 rstn=0 asynchronously mid-payload -> all outputs 0 without clock edge.

Source files
------------

// File: rtl/router_register_pkg.sv
// Shared constants for the router register slice: byte width and the
// reserved destination address that must never be latched as a header.
package router_register_pkg;
  localparam int          BYTE_W       = 8;
  localparam logic [1:0]  ADDR_INVALID = 2'b11;
endpackage

// File: rtl/router_register_if.sv
// Byte stream, FIFO status, FSM state strobes and register outputs bundled
// between the router FSM/source (master) and the register block (slave).
interface router_register_if;
  import router_register_pkg::*;

  logic              pkt_vld;
  logic [BYTE_W-1:0] din;
  logic              fifo_full;
  logic              rst_int_reg;
  logic              detect_addr;
  logic              ld_state;
  logic              laf_state;
  logic              lfd_state;
  logic              full_state;
  logic              parity_done;
  logic              low_pkt_valid;
  logic              err;
  logic [BYTE_W-1:0] d_out;

  modport master (
    output pkt_vld, din, fifo_full, rst_int_reg, detect_addr,
           ld_state, laf_state, lfd_state, full_state,
    input  parity_done, low_pkt_valid, err, d_out
  );

  modport slave (
    input  pkt_vld, din, fifo_full, rst_int_reg, detect_addr,
           ld_state, laf_state, lfd_state, full_state,
    output parity_done, low_pkt_valid, err, d_out
  );
endinterface

// File: rtl/router_register.sv
// Router register block: latches the header, buffers a byte while the FIFO is
// full, forwards bytes to the FIFO and checks the running XOR packet parity.
module router_register
  import router_register_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  router_register_if.slave   bus
);

  logic [BYTE_W-1:0] header_d, header_q;
  logic [BYTE_W-1:0] full_byte_d, full_byte_q;
  logic [BYTE_W-1:0] d_out_d, d_out_q;
  logic [BYTE_W-1:0] int_parity_d, int_parity_q;
  logic [BYTE_W-1:0] pkt_parity_d, pkt_parity_q;
  logic              low_pkt_valid_d, low_pkt_valid_q;
  logic              parity_done_d, parity_done_q;
  logic              err_d, err_q;

  // A trailing parity byte that arrived into a full FIFO is recovered from
  // the full-byte buffer once loading resumes.
  logic laf_parity_s;
  assign laf_parity_s = bus.laf_state && low_pkt_valid_q && !parity_done_q;

  // Next-state for header, buffered byte and FIFO data output.
  always_comb begin
    header_d    = header_q;
    full_byte_d = full_byte_q;
    d_out_d     = d_out_q;

    if (bus.detect_addr && bus.pkt_vld && (bus.din[1:0] != ADDR_INVALID)) begin
      header_d = bus.din;
    end else begin
      header_d = header_q;
    end

    if (bus.ld_state && bus.fifo_full) begin
      full_byte_d = bus.din;
    end else begin
      full_byte_d = full_byte_q;
    end

    if (bus.lfd_state) begin
      d_out_d = header_q;
    end else if (bus.ld_state && !bus.fifo_full) begin
      d_out_d = bus.din;
    end else if (bus.laf_state) begin
      d_out_d = full_byte_q;
    end else begin
      d_out_d = d_out_q;
    end
  end

  // Next-state for status flags, parity accumulator, captured parity and error.
  always_comb begin
    low_pkt_valid_d = low_pkt_valid_q;
    parity_done_d   = parity_done_q;
    int_parity_d    = int_parity_q;
    pkt_parity_d    = pkt_parity_q;
    err_d           = err_q;

    if (bus.rst_int_reg) begin
      low_pkt_valid_d = 1'b0;
    end else if (bus.ld_state && !bus.pkt_vld) begin
      low_pkt_valid_d = 1'b1;
    end else begin
      low_pkt_valid_d = low_pkt_valid_q;
    end

    if (bus.detect_addr) begin
      parity_done_d = 1'b0;
    end else if ((bus.ld_state && !bus.fifo_full && !bus.pkt_vld) || laf_parity_s) begin
      parity_done_d = 1'b1;
    end else begin
      parity_done_d = parity_done_q;
    end

    if (bus.detect_addr) begin
      int_parity_d = {BYTE_W{1'b0}};
    end else if (bus.lfd_state && bus.pkt_vld) begin
      int_parity_d = int_parity_q ^ header_q;
    end else if (bus.ld_state && bus.pkt_vld && !bus.full_state) begin
      int_parity_d = int_parity_q ^ bus.din;
    end else begin
      int_parity_d = int_parity_q;
    end

    if (bus.ld_state && !bus.pkt_vld && !bus.fifo_full) begin
      pkt_parity_d = bus.din;
    end else if (laf_parity_s) begin
      pkt_parity_d = full_byte_q;
    end else begin
      pkt_parity_d = pkt_parity_q;
    end

    // Compared only after parity_done is registered, so err lags it by a cycle.
    if (bus.detect_addr) begin
      err_d = 1'b0;
    end else if (parity_done_q) begin
      err_d = (int_parity_q != pkt_parity_q);
    end else begin
      err_d = err_q;
    end
  end

  // State registers; reset clears every byte register and flag.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      header_q        <= {BYTE_W{1'b0}};
      full_byte_q     <= {BYTE_W{1'b0}};
      d_out_q         <= {BYTE_W{1'b0}};
      int_parity_q    <= {BYTE_W{1'b0}};
      pkt_parity_q    <= {BYTE_W{1'b0}};
      low_pkt_valid_q <= 1'b0;
      parity_done_q   <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      header_q        <= header_d;
      full_byte_q     <= full_byte_d;
      d_out_q         <= d_out_d;
      int_parity_q    <= int_parity_d;
      pkt_parity_q    <= pkt_parity_d;
      low_pkt_valid_q <= low_pkt_valid_d;
      parity_done_q   <= parity_done_d;
      err_q           <= err_d;
    end
  end

  assign bus.d_out         = d_out_q;
  assign bus.parity_done   = parity_done_q;
  assign bus.low_pkt_valid = low_pkt_valid_q;
  assign bus.err           = err_q;

endmodule

// File: tb/tb_router_register.sv
// Randomised packet-level bench for router_register: expected bytes and
// parity outcome come from packet arithmetic (XOR of header and payload).
module tb_router_register;

  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_bad;
  logic [7:0] last_out;
  logic [7:0] last_hdr;

  router_register_if bus();

  router_register dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic det, input logic lfd, input logic ld, input logic laf,
                       input logic fst, input logic rint, input logic pv, input logic ff,
                       input logic [7:0] d);
    bus.detect_addr = det;
    bus.lfd_state   = lfd;
    bus.ld_state    = ld;
    bus.laf_state   = laf;
    bus.full_state  = fst;
    bus.rst_int_reg = rint;
    bus.pkt_vld     = pv;
    bus.fifo_full   = ff;
    bus.din         = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  // One byte through LOAD_DATA; optionally stalled by a full FIFO and
  // recovered through FIFO_FULL_STATE / LOAD_AFTER_FULL.
  task automatic send_byte(input logic [7:0] b, input logic pv, input bit stall);
    if (!stall) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pv, 1'b0, b);
      tick();
      check("fwd_byte", bus.d_out, b);
      last_out = b;
    end else begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, pv, 1'b1, b);
      tick();
      check("stall_hold", bus.d_out, last_out);
      for (int k = 0; k < int'($urandom_range(1, 2)); k++) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, pv, 1'b1, 8'($urandom));
        tick();
        check("full_hold", bus.d_out, last_out);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, pv, 1'b0, 8'($urandom));
      tick();
      check("laf_byte", bus.d_out, b);
      last_out = b;
    end
  endtask

  task automatic send_pkt(input bit fixed, input logic [7:0] fixed_hdr,
                          input bit corrupt, input bit allow_stall);
    logic [7:0] hdr;
    logic [7:0] par;
    logic [7:0] b;
    int         len;
    if (fixed) begin
      hdr = fixed_hdr;
    end else begin
      hdr = {6'($urandom_range(1, 20)), 2'($urandom_range(0, 2))};
    end
    len = int'(hdr[7:2]);
    par = hdr;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, hdr);
    tick();
    check("det_pdone_clr", {7'd0, bus.parity_done}, 8'd0);
    check("det_err_clr", {7'd0, bus.err}, 8'd0);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom));
    tick();
    check("hdr_out", bus.d_out, hdr);
    last_out = hdr;
    last_hdr = hdr;

    for (int i = 0; i < len; i++) begin
      b   = 8'($urandom);
      par = par ^ b;
      send_byte(b, 1'b1, allow_stall && ($urandom_range(0, 3) == 0));
    end
    check("lpv_low_in_payload", {7'd0, bus.low_pkt_valid}, 8'd0);

    send_byte(corrupt ? ~par : par, 1'b0, allow_stall && ($urandom_range(0, 2) == 0));

    idle();
    tick();
    check("parity_done", {7'd0, bus.parity_done}, 8'd1);
    check("low_pkt_valid", {7'd0, bus.low_pkt_valid}, 8'd1);
    tick();
    check("err", {7'd0, bus.err}, {7'd0, corrupt});
    tick();
    check("err_hold", {7'd0, bus.err}, {7'd0, corrupt});

    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick();
    check("lpv_clr", {7'd0, bus.low_pkt_valid}, 8'd0);
    check("err_hold_rint", {7'd0, bus.err}, {7'd0, corrupt});
    idle();
  endtask

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    last_out = 8'h00;
    last_hdr = 8'h00;
    rstn     = 1'b0;
    idle();
    tick();
    tick();
    check("rst_dout", bus.d_out, 8'h00);
    check("rst_pdone", {7'd0, bus.parity_done}, 8'd0);
    check("rst_lpv", {7'd0, bus.low_pkt_valid}, 8'd0);
    check("rst_err", {7'd0, bus.err}, 8'd0);
    rstn = 1'b1;
    tick();

    // Header 0x3A, 14 bytes, clean then with inverted parity.
    send_pkt(1'b1, 8'h3A, 1'b0, 1'b0);
    send_pkt(1'b1, 8'h3A, 1'b1, 1'b0);

    for (int p = 0; p < 10; p++) begin
      send_pkt(1'b0, 8'h00, bit'($urandom_range(0, 1)), 1'b1);
    end

    // Address 3 must not overwrite the latched header.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3B);
    tick();
    check("bad_addr_pdone", {7'd0, bus.parity_done}, 8'd0);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hC4);
    tick();
    check("bad_addr_hdr", bus.d_out, last_hdr);

    // Illegal simultaneous lfd/ld: header still wins.
    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h99);
    tick();
    check("prio_lfd", bus.d_out, last_hdr);
    // Simultaneous ld (not full) and laf: din wins over buffered byte.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h66);
    tick();
    check("prio_ld", bus.d_out, 8'h66);

    // Explicit full-FIFO case with 0x55.
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
    tick();
    check("ff_hold", bus.d_out, 8'h66);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'hAA);
    tick();
    check("ff_laf55", bus.d_out, 8'h55);
    idle();
    tick();

    // Asynchronous reset mid-payload.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h3A);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'($urandom_range(1, 255)));
      tick();
    end
    #2;
    rstn = 1'b0;
    #1;
    check("arst_dout", bus.d_out, 8'h00);
    check("arst_pdone", {7'd0, bus.parity_done}, 8'd0);
    check("arst_lpv", {7'd0, bus.low_pkt_valid}, 8'd0);
    check("arst_err", {7'd0, bus.err}, 8'd0);
    idle();
    tick();
    rstn = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77);
    tick();
    check("arst_hdr_clr", bus.d_out, 8'h00);
    idle();
    tick();
    send_pkt(1'b0, 8'h00, 1'b0, 1'b1);
    send_pkt(1'b0, 8'h00, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
